sonar_scheduler: RTL and testbench



---
 rtl/sonar_scheduler.sv | 161 ++++++++++++++++
 tb/tb_sonar_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scheduler.sv
// Trigger scheduler for the HC04 sonar block: fires sensors round-robin or all at once,
// snoops result handshakes, flags per-sensor timeouts and spaces measurements by a gap.
module sonar_scheduler #(
  parameter int unsigned NUM     = 6,
  parameter int unsigned TIMEOUT = 1500000,
  parameter int unsigned GAP_RST = 500000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     cfg_ctrl,
  input  logic [23:0]    cfg_data,
  input  logic           cfg_wr,
  output logic [3:0]     trig_ctrl,
  output logic [23:0]    trig_data,
  output logic           trig_wr,
  input  logic [2:0]     res_sel,
  input  logic           res_wr,
  input  logic           res_wr_rdy,
  output logic [NUM-1:0] timeout_mask,
  output logic           busy
);

  localparam int unsigned    PTR_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [NUM-1:0] ONE   = {{(NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT, S_GAP} state_t;

  state_t           r_state, w_next_state;
  logic             r_enable;
  logic             r_mode;
  logic [NUM-1:0]   r_mask;
  logic [23:0]      r_gap;
  logic [PTR_W-1:0] r_ptr;
  logic [NUM-1:0]   r_pending;
  logic [23:0]      r_timer;
  logic [NUM-1:0]   r_timeout_mask;

  logic             w_go;
  logic [NUM-1:0]   w_group;
  logic             w_acc;
  logic [NUM-1:0]   w_clr;
  logic [NUM-1:0]   w_pend_post;
  logic             w_timer_last;
  logic             w_gap_done;
  logic [NUM-1:0]   w_tmo_set;
  logic [NUM-1:0]   w_tmo_clr;
  logic [PTR_W-1:0] w_first_ptr;
  logic [PTR_W-1:0] w_hi_ptr;
  logic             w_hi_found;
  logic [PTR_W-1:0] w_next_ptr;

  assign w_go         = r_enable && (r_mask != '0);
  assign w_group      = r_mode ? r_mask : (ONE << r_ptr);
  assign w_acc        = res_wr && res_wr_rdy && (32'(res_sel) < NUM);
  assign w_clr        = w_acc ? (ONE << res_sel) : '0;
  assign w_pend_post  = r_pending & ~w_clr;
  assign w_timer_last = (r_timer == 24'(TIMEOUT - 1));
  assign w_gap_done   = (r_gap == '0) || (r_timer >= (r_gap - 24'd1));
  assign w_tmo_set    = ((r_state == S_WAIT) && (w_pend_post != '0) && w_timer_last) ? w_pend_post : '0;
  assign w_tmo_clr    = (cfg_wr && (cfg_ctrl == 4'd2)) ? cfg_data[NUM-1:0] : '0;
  assign timeout_mask = r_timeout_mask;

  // Descending scan: the last hit is the lowest index, giving both the lowest set bit
  // and the lowest set bit above r_ptr; wrap falls back to the lowest (possibly r_ptr itself).
  always_comb begin
    w_first_ptr = '0;
    w_hi_ptr    = '0;
    w_hi_found  = 1'b0;
    for (int unsigned j = NUM; j > 0; j--) begin
      if (r_mask[j-1]) begin
        w_first_ptr = PTR_W'(j - 1);
        if ((j - 1) > 32'(r_ptr)) begin
          w_hi_ptr   = PTR_W'(j - 1);
          w_hi_found = 1'b1;
        end
      end
    end
    w_next_ptr = w_hi_found ? w_hi_ptr : w_first_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_go) w_next_state = S_FIRE;
      S_FIRE: w_next_state = S_WAIT;
      S_WAIT: if ((w_pend_post == '0) || w_timer_last) w_next_state = S_GAP;
      S_GAP:  if (w_gap_done) w_next_state = w_go ? S_FIRE : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    trig_ctrl = '0;
    trig_wr   = 1'b0;
    trig_data = '0;
    busy      = (r_state != S_IDLE);
    if (r_state == S_FIRE) begin
      trig_wr   = 1'b1;
      trig_data = 24'(w_group);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= 1'b0;
      r_mode   <= 1'b0;
      r_mask   <= '0;
      r_gap    <= 24'(GAP_RST);
    end else if (cfg_wr) begin
      if (cfg_ctrl == 4'd0) begin
        r_enable <= cfg_data[23];
        r_mode   <= cfg_data[22];
        r_mask   <= cfg_data[NUM-1:0];
      end else if (cfg_ctrl == 4'd1) begin
        r_gap <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr          <= '0;
      r_pending      <= '0;
      r_timer        <= '0;
      r_timeout_mask <= '0;
    end else begin
      r_timeout_mask <= (r_timeout_mask & ~w_tmo_clr) | w_tmo_set;
      case (r_state)
        S_IDLE: if (w_go && !r_mode) r_ptr <= w_first_ptr;
        S_FIRE: begin
          r_pending <= w_group;
          r_timer   <= '0;
        end
        S_WAIT: begin
          if ((w_pend_post == '0) || w_timer_last) begin
            r_pending <= '0;
            r_timer   <= '0;
          end else begin
            r_pending <= w_pend_post;
            r_timer   <= r_timer + 24'd1;
          end
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_timer <= '0;
            if (w_go && !r_mode) r_ptr <= w_next_ptr;
          end else begin
            r_timer <= r_timer + 24'd1;
          end
        end
        default: r_timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with TIMEOUT=100; cycle numbers are absolute
// posedge counts observed at the following falling edge.
module tb_sonar_scheduler;
  localparam int unsigned NUM = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     cfg_ctrl = '0;
  logic [23:0]    cfg_data = '0;
  logic           cfg_wr = 1'b0;
  logic [3:0]     trig_ctrl;
  logic [23:0]    trig_data;
  logic           trig_wr;
  logic [2:0]     res_sel = '0;
  logic           res_wr = 1'b0;
  logic           res_wr_rdy = 1'b0;
  logic [NUM-1:0] timeout_mask;
  logic           busy;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int n_fire = 0;
  int last_fire = 0;

  sonar_scheduler #(.NUM(NUM), .TIMEOUT(100), .GAP_RST(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_ctrl(cfg_ctrl), .cfg_data(cfg_data), .cfg_wr(cfg_wr),
    .trig_ctrl(trig_ctrl), .trig_data(trig_data), .trig_wr(trig_wr),
    .res_sel(res_sel), .res_wr(res_wr), .res_wr_rdy(res_wr_rdy),
    .timeout_mask(timeout_mask), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (trig_wr === 1'b1) n_fire <= n_fire + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic tick_until(input int target);
    checks++;
    if (cyc > target) $display("FAIL schedule: at cycle %0d, required <= %0d", cyc, target);
    else passed++;
    while (cyc < target) @(negedge clk);
  endtask

  task automatic cfg(input logic [3:0] c, input logic [23:0] d);
    cfg_ctrl = c; cfg_data = d; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic reply(input logic [2:0] sel);
    res_sel = sel; res_wr = 1'b1; res_wr_rdy = 1'b1;
    @(negedge clk);
    res_wr = 1'b0; res_wr_rdy = 1'b0;
  endtask

  task automatic wait_fire(input int budget, output bit ok, output int at, output logic [23:0] d);
    ok = 1'b0; at = 0; d = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (trig_wr === 1'b1) begin ok = 1'b1; at = cyc; d = trig_data; end
    end
    checks++;
    if (!ok) $display("FAIL fire_wait: no trig_wr within %0d cycles", budget);
    else passed++;
    last_fire = at;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (trig_wr !== 1'b0) $display("FAIL rst_trig_wr: got %b want 0", trig_wr); else passed++;
    checks++; if (trig_data !== 24'h0) $display("FAIL rst_trig_data: got %h want 000000", trig_data); else passed++;
    checks++; if (trig_ctrl !== 4'h0) $display("FAIL rst_trig_ctrl: got %h want 0", trig_ctrl); else passed++;
    checks++; if (timeout_mask !== 6'h0) $display("FAIL rst_tmo: got %b want 000000", timeout_mask); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (busy !== 1'b0 || n_fire != 0) $display("FAIL idle_after_rst: busy %b fires %0d want 0/0", busy, n_fire); else passed++;
  endtask

  task automatic test_sequential();
    bit ok; int at; int t0; int t1; logic [23:0] d;
    cfg(4'd1, 24'd20);
    cfg(4'd0, 24'h800005);
    wait_fire(20, ok, at, d);
    t0 = at;
    checks++; if (d !== 24'h000001) $display("FAIL seq_fire0: got %h want 000001", d); else passed++;
    checks++; if (trig_ctrl !== 4'h0) $display("FAIL fire_ctrl: got %h want 0", trig_ctrl); else passed++;
    tick();
    checks++; if (trig_wr !== 1'b0 || trig_data !== 24'h0) $display("FAIL pulse_end: wr %b data %h want 0/000000", trig_wr, trig_data); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL busy_wait: got %b want 1", busy); else passed++;
    tick_until(t0 + 30);
    reply(3'd0);
    wait_fire(100, ok, at, d);
    t1 = at;
    checks++; if (at != t0 + 51) $display("FAIL seq_period: got %0d want %0d", at - t0, 51); else passed++;
    checks++; if (d !== 24'h000004) $display("FAIL seq_fire1: got %h want 000004", d); else passed++;
    tick_until(t1 + 10);
    reply(3'd2);
    wait_fire(100, ok, at, d);
    checks++; if (at != t1 + 31) $display("FAIL seq_period2: got %0d want %0d", at - t1, 31); else passed++;
    checks++; if (d !== 24'h000001) $display("FAIL seq_wrap: got %h want 000001", d); else passed++;
  endtask

  task automatic test_disable();
    int t2; int nf;
    t2 = last_fire;
    tick_until(t2 + 5);
    cfg(4'd0, 24'h000005);
    tick_until(t2 + 40);
    reply(3'd0);
    tick_until(t2 + 60);
    checks++; if (busy !== 1'b1) $display("FAIL dis_gap_busy: got %b want 1", busy); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL dis_idle: got %b want 0", busy); else passed++;
    checks++; if (timeout_mask !== 6'h0) $display("FAIL dis_tmo: got %b want 000000", timeout_mask); else passed++;
    nf = n_fire;
    repeat (150) tick();
    checks++; if (n_fire != nf) $display("FAIL dis_no_fire: got %0d extra pulses want 0", n_fire - nf); else passed++;
  endtask

  task automatic test_broadcast_timeout();
    bit ok; int at; int t; logic [23:0] d;
    cfg(4'd0, 24'hC0003F);
    wait_fire(20, ok, at, d);
    t = at;
    checks++; if (d !== 24'h00003F) $display("FAIL bc_fire: got %h want 00003f", d); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick_until(t + 2 + i);
      reply(3'(i));
    end
    reply(3'd6);
    cfg(4'd0, 24'h40003F);
    tick_until(t + 100);
    checks++; if (timeout_mask !== 6'h00) $display("FAIL bc_tmo_early: got %b want 000000", timeout_mask); else passed++;
    tick();
    checks++; if (timeout_mask !== 6'b100000) $display("FAIL bc_tmo: got %b want 100000", timeout_mask); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL bc_gap_busy: got %b want 1", busy); else passed++;
    tick_until(t + 121);
    checks++; if (busy !== 1'b0) $display("FAIL bc_idle: got %b want 0", busy); else passed++;
    cfg(4'd2, 24'h000020);
    checks++; if (timeout_mask !== 6'h00) $display("FAIL tmo_clear: got %b want 000000", timeout_mask); else passed++;
  endtask

  task automatic test_last_on_timeout();
    bit ok; int at; int t; logic [23:0] d;
    cfg(4'd0, 24'h800008);
    wait_fire(20, ok, at, d);
    t = at;
    checks++; if (d !== 24'h000008) $display("FAIL lt_fire: got %h want 000008", d); else passed++;
    cfg(4'd0, 24'h000008);
    tick_until(t + 100);
    checks++; if (busy !== 1'b1) $display("FAIL lt_wait_busy: got %b want 1", busy); else passed++;
    reply(3'd3);
    checks++; if (timeout_mask !== 6'h00) $display("FAIL lt_tmo: got %b want 000000", timeout_mask); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL lt_gap_busy: got %b want 1", busy); else passed++;
    tick_until(t + 121);
    checks++; if (busy !== 1'b0) $display("FAIL lt_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_not_ready();
    bit ok; int at; int t; logic [23:0] d;
    cfg(4'd0, 24'hC00003);
    wait_fire(20, ok, at, d);
    t = at;
    checks++; if (d !== 24'h000003) $display("FAIL nr_fire: got %h want 000003", d); else passed++;
    res_sel = 3'd1; res_wr = 1'b1; res_wr_rdy = 1'b0;
    cfg(4'd0, 24'h400003);
    tick_until(t + 3);
    res_sel = 3'd0; res_wr_rdy = 1'b1;
    tick();
    res_sel = 3'd1; res_wr_rdy = 1'b0;
    tick_until(t + 101);
    res_wr = 1'b0;
    checks++; if (timeout_mask !== 6'b000010) $display("FAIL nr_tmo: got %b want 000010", timeout_mask); else passed++;
    tick_until(t + 121);
    checks++; if (busy !== 1'b0) $display("FAIL nr_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    bit ok; int at; int t; int nf; logic [23:0] d;
    cfg(4'd0, 24'h800001);
    wait_fire(20, ok, at, d);
    t = at;
    tick_until(t + 10);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy); else passed++;
    checks++; if (trig_wr !== 1'b0 || trig_data !== 24'h0) $display("FAIL arst_trig: wr %b data %h want 0/000000", trig_wr, trig_data); else passed++;
    checks++; if (timeout_mask !== 6'h00) $display("FAIL arst_tmo: got %b want 000000", timeout_mask); else passed++;
    nf = n_fire;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (150) tick();
    checks++; if (n_fire != nf || busy !== 1'b0) $display("FAIL arst_quiet: extra pulses %0d busy %b want 0/0", n_fire - nf, busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_disable();
    test_broadcast_timeout();
    test_last_on_timeout();
    test_not_ready();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
